// File: rtl/osc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : osc_freq_meter
//  Purpose  : Measures the frequency of one of N_CH asynchronous ring
//             oscillators by counting its rising edges over a gate window of
//             2^gate_sel clk cycles. Holds the unselected oscillators in
//             reset, allows a settle time after releasing the selected one,
//             and hands the result out on a valid/ready interface. In
//             continuous mode the meter re-gates the same channel straight
//             after each accepted result.
//  Ports    : clk            - single clock, rising edge
//             rst            - synchronous active-high reset
//             start_i        - measurement request (honoured in IDLE only)
//             cont_i         - continuous mode request
//             ch_sel_i       - channel to measure
//             gate_sel_i     - gate length exponent
//             osc_in_i       - asynchronous oscillator outputs
//             osc_rst_o      - per-channel oscillator reset, active high
//             busy_o         - high whenever the meter is not IDLE
//             result_o       - rising edges counted in the last gate
//             result_ch_o    - channel the result belongs to
//             ovf_o          - result saturated
//             result_valid_o - result handshake, valid
//             result_ready_i - result handshake, ready
//  Revision : 1.0 - initial release
// ============================================================================
module osc_freq_meter #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 4,
    parameter int SETTLE_CYC = 16,
    // Channel-select width; may be widened so out-of-range selects can be
    // presented and rejected.
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [CH_W-1:0]  ch_sel_i,
    input  logic [GATE_W-1:0] gate_sel_i,
    input  logic [N_CH-1:0]  osc_in_i,
    output logic [N_CH-1:0]  osc_rst_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic [CH_W-1:0]  result_ch_o,
    output logic             ovf_o,
    output logic             result_valid_o,
    input  logic             result_ready_i
);

    // Gate down-counter must hold 2^(2^GATE_W - 1) - 1.
    localparam int c_GC_W = 2 ** GATE_W;
    localparam int c_ST_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GATE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [GATE_W-1:0]   gate_q;
    logic                cont_q;
    logic [c_ST_W-1:0]   settle_q;
    logic [c_GC_W-1:0]   gcnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_acc_q;
    logic                cap_q;
    logic [N_CH-1:0]     sync1_q;
    logic [N_CH-1:0]     sync2_q;
    logic [N_CH-1:0]     prev_q;
    logic [N_CH-1:0]     osc_rst_q;
    logic                busy_q;
    logic [CNT_W-1:0]    result_q;
    logic [CH_W-1:0]     result_ch_q;
    logic                ovf_q;
    logic                valid_q;

    logic [N_CH-1:0]     w_rise;
    logic                w_det;
    logic                w_ch_ok;
    logic [c_GC_W-1:0]   w_gate_load;

    // All oscillators but the selected one stay in reset.
    function automatic logic [N_CH-1:0] f_rst_mask(input logic [CH_W-1:0] ch);
        logic [N_CH-1:0] m;
        m = '1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == i[CH_W-1:0]) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    assign w_rise      = sync2_q & ~prev_q;
    assign w_ch_ok     = ({1'b0, ch_sel_i} < (CH_W + 1)'(N_CH));
    // Down-counter preload: gate runs for load+1 = 2^gate_q cycles.
    assign w_gate_load = (c_GC_W'(1) << gate_q) - c_GC_W'(1);

    always_comb begin
        w_det = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == i[CH_W-1:0]) begin
                w_det = w_rise[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            gate_q      <= '0;
            cont_q      <= 1'b0;
            settle_q    <= '0;
            gcnt_q      <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            cap_q       <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            osc_rst_q   <= '1;
            busy_q      <= 1'b0;
            result_q    <= '0;
            result_ch_q <= '0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sync1_q <= osc_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            case (state_q)
                S_IDLE: begin
                    osc_rst_q <= '1;
                    if (start_i && w_ch_ok) begin
                        ch_q      <= ch_sel_i;
                        gate_q    <= gate_sel_i;
                        cont_q    <= cont_i;
                        settle_q  <= c_ST_W'(SETTLE_CYC - 1);
                        osc_rst_q <= f_rst_mask(ch_sel_i);
                        busy_q    <= 1'b1;
                        state_q   <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (settle_q == '0) begin
                        cnt_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        gcnt_q    <= w_gate_load;
                        state_q   <= S_GATE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end

                S_GATE: begin
                    // The last gate cycle's edge lands at the DONE-entry edge,
                    // so the capture happens one cycle into DONE.
                    if (w_det) begin
                        if (cnt_q == '1) begin
                            ovf_acc_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    if (gcnt_q == '0) begin
                        cap_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        gcnt_q <= gcnt_q - 1'b1;
                    end
                end

                S_DONE: begin
                    if (cap_q) begin
                        cap_q       <= 1'b0;
                        result_q    <= cnt_q;
                        result_ch_q <= ch_q;
                        ovf_q       <= ovf_acc_q;
                        valid_q     <= 1'b1;
                    end else if (valid_q && result_ready_i) begin
                        valid_q <= 1'b0;
                        if (cont_q && cont_i) begin
                            // Oscillator keeps running: no settle needed.
                            cnt_q     <= '0;
                            ovf_acc_q <= 1'b0;
                            gcnt_q    <= w_gate_load;
                            state_q   <= S_GATE;
                        end else begin
                            osc_rst_q <= '1;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign osc_rst_o      = osc_rst_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_ch_o    = result_ch_q;
    assign ovf_o          = ovf_q;
    assign result_valid_o = valid_q;

endmodule
`default_nettype wire
